// File: rtl/kira_bridge_pkg.sv
// Shared types and helpers for the host-to-cluster access bridge.
package kira_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } bridge_state_e;

  // Lowest imem address bit of the cluster-select field.
  function automatic int sel_lsb(input int n_pe);
    return 10 + $clog2(n_pe);
  endfunction

endpackage

// File: rtl/kira_imem_router.sv
// Registered decode/demux of the host imem write port onto per-cluster ports.
module kira_imem_router
  import kira_bridge_pkg::*;
#(
  parameter int CL               = 8,
  parameter int N_PE_PER_CLUSTER = 16,
  parameter int IMEM_AW          = 10 + $clog2(CL * N_PE_PER_CLUSTER)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           imem_dina,
  input  logic [3:0]            imem_wea,
  input  logic [IMEM_AW-1:0]    imem_addra,
  output logic [CL*32-1:0]      cl_imem_dina,
  output logic [CL*4-1:0]       cl_imem_wea,
  output logic [CL*IMEM_AW-1:0] cl_imem_addra
);

  localparam int CL_W    = (CL > 1) ? $clog2(CL) : 1;
  localparam int SEL_LSB = sel_lsb(N_PE_PER_CLUSTER);

  logic [CL_W-1:0] idx;
  logic [CL-1:0]   hit;

  generate
    if (CL > 1) begin : g_idx
      assign idx = imem_addra[SEL_LSB +: CL_W];
    end else begin : g_idx_single
      assign idx = '0;
    end
  endgenerate

  // Out-of-range selects leave every cluster port at zero, dropping the write.
  always_comb begin
    hit = '0;
    if (32'(idx) < CL) hit[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cl_imem_dina  <= '0;
      cl_imem_wea   <= '0;
      cl_imem_addra <= '0;
    end else begin
      for (int i = 0; i < CL; i++) begin
        cl_imem_dina[i*32 +: 32]           <= hit[i] ? imem_dina  : '0;
        cl_imem_wea[i*4 +: 4]              <= hit[i] ? imem_wea   : '0;
        cl_imem_addra[i*IMEM_AW +: IMEM_AW] <= hit[i] ? imem_addra : '0;
      end
    end
  end

endmodule

// File: rtl/kira_host_cluster_bridge.sv
// Host-to-cluster bridge: TCDM access engine with broadcast/timeout, imem
// write router and sticky finish aggregation.
module kira_host_cluster_bridge
  import kira_bridge_pkg::*;
#(
  parameter int CL               = 8,
  parameter int N_PE_PER_CLUSTER = 16,
  parameter int IMEM_AW          = 10 + $clog2(CL * N_PE_PER_CLUSTER),
  parameter int DW               = 32,
  parameter int AW               = 32,
  parameter int TO_W             = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_req_valid,
  output logic                  host_req_ready,
  input  logic                  host_req_we,
  input  logic [AW-1:0]         host_req_addr,
  input  logic [DW-1:0]         host_req_wdata,
  input  logic [CL-1:0]         host_req_mask,
  output logic                  host_rsp_valid,
  input  logic                  host_rsp_ready,
  output logic [DW-1:0]         host_rsp_rdata,
  output logic                  host_rsp_err,
  output logic [CL-1:0]         cl_req,
  output logic [CL-1:0]         cl_we,
  output logic [AW-1:0]         cl_addr,
  output logic [DW-1:0]         cl_wdata,
  input  logic [CL-1:0]         cl_gnt,
  input  logic [CL-1:0]         cl_rvalid,
  input  logic [CL*DW-1:0]      cl_rdata,
  input  logic [31:0]           imem_dina,
  input  logic [3:0]            imem_wea,
  input  logic [IMEM_AW-1:0]    imem_addra,
  output logic [CL*32-1:0]      cl_imem_dina,
  output logic [CL*4-1:0]       cl_imem_wea,
  output logic [CL*IMEM_AW-1:0] cl_imem_addra,
  input  logic [CL-1:0]         cl_finish,
  input  logic                  finish_clr,
  output logic                  finish,
  output logic [CL-1:0]         finish_vec
);

  localparam int CL_W = (CL > 1) ? $clog2(CL) : 1;
  // Counter value in the last waiting cycle; it would reach 2**TO_W-1 on that edge.
  localparam logic [TO_W-1:0] TO_LAST = ~(TO_W'(1));

  bridge_state_e   state, state_next;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [CL-1:0]   pend;
  logic [CL_W-1:0] sel_q;
  logic [TO_W-1:0] to_cnt;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  logic [CL_W-1:0] req_sel;
  logic            req_err;
  logic [CL-1:0]   pend_left;
  logic            timeout;
  logic            rd_hit;

  always_comb begin
    req_sel = '0;
    for (int i = 0; i < CL; i++) begin
      if (host_req_mask[i]) req_sel = CL_W'(i);
    end
  end

  assign req_err   = (host_req_mask == '0) ||
                     (!host_req_we && ($countones(host_req_mask) != 1));
  assign pend_left = pend & ~cl_gnt;
  assign timeout   = (to_cnt == TO_LAST);
  assign rd_hit    = cl_rvalid[sel_q];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Grants and read data take priority over a timeout landing in the same cycle.
  always_comb begin
    state_next     = state;
    host_req_ready = 1'b0;
    host_rsp_valid = 1'b0;
    cl_req         = '0;
    cl_we          = '0;
    case (state)
      IDLE: begin
        host_req_ready = 1'b1;
        if (host_req_valid) state_next = req_err ? RESP : ISSUE;
      end
      ISSUE: begin
        cl_req = pend;
        cl_we  = pend & {CL{we_q}};
        if (pend_left == '0) state_next = we_q ? RESP : WAIT_RD;
        else if (timeout)    state_next = RESP;
      end
      WAIT_RD: begin
        if (rd_hit || timeout) state_next = RESP;
      end
      RESP: begin
        host_rsp_valid = 1'b1;
        if (host_rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pend      <= '0;
      sel_q     <= '0;
      to_cnt    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state_next != state)                    to_cnt <= '0;
      else if (state == ISSUE || state == WAIT_RD) to_cnt <= to_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (host_req_valid) begin
            we_q      <= host_req_we;
            addr_q    <= host_req_addr;
            wdata_q   <= host_req_wdata;
            pend      <= host_req_mask;
            sel_q     <= req_sel;
            rsp_rdata <= '0;
            rsp_err   <= req_err;
          end
        end
        ISSUE: begin
          pend <= pend_left;
          if (pend_left != '0 && timeout) begin
            pend    <= '0;
            rsp_err <= 1'b1;
          end
        end
        WAIT_RD: begin
          if (rd_hit)       rsp_rdata <= cl_rdata[sel_q*DW +: DW];
          else if (timeout) rsp_err   <= 1'b1;
        end
        RESP: begin
          if (host_rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cl_addr        = addr_q;
  assign cl_wdata       = wdata_q;
  assign host_rsp_rdata = rsp_rdata;
  assign host_rsp_err   = rsp_err;

  // A set arriving with the clear survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      finish_vec <= '0;
      finish     <= 1'b0;
    end else begin
      finish_vec <= finish_clr ? cl_finish : (finish_vec | cl_finish);
      finish     <= &finish_vec;
    end
  end

  kira_imem_router #(
    .CL               (CL),
    .N_PE_PER_CLUSTER (N_PE_PER_CLUSTER),
    .IMEM_AW          (IMEM_AW)
  ) u_imem_router (
    .clk           (clk),
    .rst           (rst),
    .imem_dina     (imem_dina),
    .imem_wea      (imem_wea),
    .imem_addra    (imem_addra),
    .cl_imem_dina  (cl_imem_dina),
    .cl_imem_wea   (cl_imem_wea),
    .cl_imem_addra (cl_imem_addra)
  );

endmodule

// File: tb/tb_kira_host_cluster_bridge.sv
// Self-checking bench for kira_host_cluster_bridge with a cluster responder
// model and spec-level latency/response prediction.
module tb_kira_host_cluster_bridge;

  localparam int CL      = 8;
  localparam int NPE     = 16;
  localparam int IMEM_AW = 17;
  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int TO_W    = 4;
  localparam int TO_CYC  = 15;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  host_req_valid = 1'b0;
  logic                  host_req_ready;
  logic                  host_req_we = 1'b0;
  logic [AW-1:0]         host_req_addr = '0;
  logic [DW-1:0]         host_req_wdata = '0;
  logic [CL-1:0]         host_req_mask = '0;
  logic                  host_rsp_valid;
  logic                  host_rsp_ready = 1'b0;
  logic [DW-1:0]         host_rsp_rdata;
  logic                  host_rsp_err;
  logic [CL-1:0]         cl_req, cl_we;
  logic [AW-1:0]         cl_addr;
  logic [DW-1:0]         cl_wdata;
  logic [CL-1:0]         cl_gnt = '0;
  logic [CL-1:0]         cl_rvalid = '0;
  logic [CL*DW-1:0]      cl_rdata = '0;
  logic [31:0]           imem_dina = '0;
  logic [3:0]            imem_wea = '0;
  logic [IMEM_AW-1:0]    imem_addra = '0;
  logic [CL*32-1:0]      cl_imem_dina;
  logic [CL*4-1:0]       cl_imem_wea;
  logic [CL*IMEM_AW-1:0] cl_imem_addra;
  logic [CL-1:0]         cl_finish = '0;
  logic                  finish_clr = 1'b0;
  logic                  finish;
  logic [CL-1:0]         finish_vec;

  int tests = 0;
  int fails = 0;

  int            gnt_dly[CL];
  int            rv_dly;
  int            stall;
  logic [DW-1:0] rd_data[CL];

  always #5 clk = ~clk;

  kira_host_cluster_bridge #(
    .CL(CL), .N_PE_PER_CLUSTER(NPE), .IMEM_AW(IMEM_AW), .DW(DW), .AW(AW), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_we(host_req_we), .host_req_addr(host_req_addr),
    .host_req_wdata(host_req_wdata), .host_req_mask(host_req_mask),
    .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
    .host_rsp_rdata(host_rsp_rdata), .host_rsp_err(host_rsp_err),
    .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
    .cl_gnt(cl_gnt), .cl_rvalid(cl_rvalid), .cl_rdata(cl_rdata),
    .imem_dina(imem_dina), .imem_wea(imem_wea), .imem_addra(imem_addra),
    .cl_imem_dina(cl_imem_dina), .cl_imem_wea(cl_imem_wea), .cl_imem_addra(cl_imem_addra),
    .cl_finish(cl_finish), .finish_clr(finish_clr),
    .finish(finish), .finish_vec(finish_vec)
  );

  // One host transaction against clusters that grant at gnt_dly[i] cycles after
  // acceptance and return read data rv_dly cycles after the grant.
  task automatic run_txn(input string name, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [CL-1:0] mask);
    logic          ok_req, exp_err, cap_err, stable;
    logic [DW-1:0] exp_rdata, cap_rdata;
    logic [CL-1:0] exp_req;
    int            sel, spur, dmax, exp_k, rsp_k, bad;

    ok_req = (mask != '0) && (we || $countones(mask) == 1);
    sel = 0;
    dmax = 0;
    for (int i = 0; i < CL; i++) begin
      if (mask[i]) begin
        sel = i;
        if (gnt_dly[i] > dmax) dmax = gnt_dly[i];
      end
    end
    spur = (sel == 1) ? 2 : 1;
    exp_rdata = '0;
    if (!ok_req) begin
      exp_k = 1; exp_err = 1'b1;
    end else if (dmax > TO_CYC) begin
      exp_k = TO_CYC + 1; exp_err = 1'b1;
    end else if (we) begin
      exp_k = dmax + 1; exp_err = 1'b0;
    end else if (rv_dly > TO_CYC) begin
      exp_k = dmax + 1 + TO_CYC; exp_err = 1'b1;
    end else begin
      exp_k = dmax + rv_dly + 1; exp_err = 1'b0; exp_rdata = rd_data[sel];
    end

    for (int i = 0; i < CL; i++) cl_rdata[i*DW +: DW] = rd_data[i];

    @(negedge clk);
    host_req_we    = we;
    host_req_addr  = addr;
    host_req_wdata = wdata;
    host_req_mask  = mask;
    host_req_valid = 1'b1;
    tests++;
    if (host_req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s req_ready: got %b, expected 1", name, host_req_ready);
    end
    @(posedge clk);
    #1;
    host_req_valid = 1'b0;

    rsp_k = -1;
    bad = 0;
    for (int k = 1; k <= 60 && rsp_k < 0; k++) begin
      for (int i = 0; i < CL; i++) cl_gnt[i] = ok_req && mask[i] && (gnt_dly[i] == k);
      cl_rvalid = '0;
      if (ok_req && !we) begin
        if (k == dmax + rv_dly) cl_rvalid[sel] = 1'b1;
        if (k == dmax + 1 && rv_dly > 1) cl_rvalid[spur] = 1'b1;
      end
      @(negedge clk);
      for (int i = 0; i < CL; i++)
        exp_req[i] = ok_req && mask[i] && (k <= gnt_dly[i]) && (k <= TO_CYC);
      if (cl_req !== exp_req || cl_we !== (exp_req & {CL{we}})) bad++;
      if (exp_req != '0 && (cl_addr !== addr || cl_wdata !== wdata)) bad++;
      if (host_rsp_valid === 1'b1) rsp_k = k;
      else if (host_req_ready !== 1'b0) bad++;
      if (rsp_k < 0) begin
        @(posedge clk);
        #1;
      end
    end
    cl_gnt = '0;
    cl_rvalid = '0;

    tests++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL %s strobes: %0d bad cycles, expected 0", name, bad);
    end
    tests++;
    if (rsp_k != exp_k) begin
      fails++;
      $display("[TB] FAIL %s rsp_cycle: got %0d, expected %0d", name, rsp_k, exp_k);
    end
    tests++;
    if (host_rsp_err !== exp_err) begin
      fails++;
      $display("[TB] FAIL %s err: got %b, expected %b", name, host_rsp_err, exp_err);
    end
    tests++;
    if (host_rsp_rdata !== exp_rdata) begin
      fails++;
      $display("[TB] FAIL %s rdata: got %h, expected %h", name, host_rsp_rdata, exp_rdata);
    end

    cap_err = host_rsp_err;
    cap_rdata = host_rsp_rdata;
    stable = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      if (host_rsp_valid !== 1'b1 || host_rsp_err !== cap_err || host_rsp_rdata !== cap_rdata) stable = 1'b0;
    end
    if (stall > 0) begin
      tests++;
      if (!stable) begin
        fails++;
        $display("[TB] FAIL %s rsp_hold: got unstable, expected stable for %0d cycles", name, stall);
      end
    end

    host_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    host_rsp_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (host_rsp_valid !== 1'b0 || host_req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s rsp_done: got valid=%b ready=%b, expected valid=0 ready=1",
               name, host_rsp_valid, host_req_ready);
    end
  endtask

  task automatic set_gnt_all(input int d);
    for (int i = 0; i < CL; i++) gnt_dly[i] = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (host_rsp_valid !== 1'b0 || host_rsp_rdata !== '0 || host_rsp_err !== 1'b0 ||
        cl_req !== '0 || cl_we !== '0 || cl_addr !== '0 || cl_wdata !== '0 ||
        cl_imem_dina !== '0 || cl_imem_wea !== '0 || cl_imem_addra !== '0 ||
        finish_vec !== '0 || finish !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got rsp_valid=%b req=%h finish_vec=%h finish=%b, expected all zero",
               host_rsp_valid, cl_req, finish_vec, finish);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (host_req_ready !== 1'b1 || host_rsp_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_ready: got ready=%b valid=%b, expected ready=1 valid=0",
               host_req_ready, host_rsp_valid);
    end
  endtask

  task automatic test_single_write;
    set_gnt_all(99);
    gnt_dly[0] = 1;
    rv_dly = 1;
    stall = 0;
    run_txn("wr_c0", 1'b1, 32'h40, 32'hDEADBEEF, 8'h01);
  endtask

  task automatic test_broadcast;
    set_gnt_all(99);
    gnt_dly[0] = 1; gnt_dly[2] = 3; gnt_dly[5] = 2; gnt_dly[7] = 6;
    stall = 2;
    run_txn("bcast_a5", 1'b1, 32'h1000, 32'hCAFEF00D, 8'hA5);
  endtask

  task automatic test_read;
    set_gnt_all(99);
    gnt_dly[3] = 2;
    rv_dly = 4;
    stall = 1;
    for (int i = 0; i < CL; i++) rd_data[i] = $urandom;
    rd_data[3] = 32'h12345678;
    run_txn("rd_c3", 1'b0, 32'h80, 32'h0, 8'h08);
  endtask

  task automatic test_errors;
    set_gnt_all(1);
    stall = 0;
    run_txn("rd_multi", 1'b0, 32'h44, 32'h0, 8'h03);
    run_txn("mask_zero", 1'b1, 32'h48, 32'h55AA55AA, 8'h00);
  endtask

  task automatic test_timeout;
    set_gnt_all(99);
    stall = 5;
    run_txn("wr_timeout", 1'b1, 32'h200, 32'h0BADF00D, 8'h10);
    set_gnt_all(99);
    gnt_dly[1] = TO_CYC;
    stall = 0;
    run_txn("gnt_at_limit", 1'b1, 32'h204, 32'h11112222, 8'h02);
    set_gnt_all(99);
    gnt_dly[2] = 3;
    rv_dly = 99;
    run_txn("rd_timeout", 1'b0, 32'h208, 32'h0, 8'h04);
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    host_req_we = 1'b1;
    host_req_mask = 8'hFF;
    host_req_addr = 32'h300;
    host_req_wdata = 32'h77777777;
    host_req_valid = 1'b1;
    @(posedge clk);
    #1;
    host_req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (cl_req !== 8'hFF) begin
      fails++;
      $display("[TB] FAIL rstmid_issue: got req=%h, expected ff", cl_req);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (cl_req !== '0 || cl_we !== '0 || host_rsp_valid !== 1'b0 || host_req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rstmid_abort: got req=%h valid=%b ready=%b, expected 00/0/1",
               cl_req, host_rsp_valid, host_req_ready);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (host_rsp_valid !== 1'b0 || cl_req !== '0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("[TB] FAIL rstmid_quiet: got %0d active cycles, expected 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    logic          we;
    logic [CL-1:0] mask;
    for (int n = 0; n < 12; n++) begin
      we = 1'($urandom_range(0, 1));
      if (!we && $urandom_range(0, 9) < 8) mask = 8'(1) << $urandom_range(0, 7);
      else mask = 8'($urandom);
      for (int i = 0; i < CL; i++) gnt_dly[i] = $urandom_range(1, 6);
      if ($urandom_range(0, 9) == 0) gnt_dly[$urandom_range(0, 7)] = 99;
      rv_dly = $urandom_range(1, 6);
      stall = $urandom_range(0, 3);
      for (int i = 0; i < CL; i++) rd_data[i] = $urandom;
      run_txn($sformatf("rand%0d", n), we, $urandom, $urandom, mask);
    end
  endtask

  task automatic test_imem;
    logic [31:0]           d;
    logic [3:0]            w;
    logic [IMEM_AW-1:0]    a;
    logic [2:0]            idx;
    logic [CL*32-1:0]      ed;
    logic [CL*4-1:0]       ew;
    logic [CL*IMEM_AW-1:0] ea;
    @(negedge clk);
    for (int n = 0; n < 17; n++) begin
      d = $urandom;
      w = 4'($urandom_range(1, 15));
      a = IMEM_AW'($urandom);
      if (n == 0) a[16:14] = 3'd6;
      idx = a[16:14];
      imem_dina = d;
      imem_wea = w;
      imem_addra = a;
      ed = '0; ew = '0; ea = '0;
      ed[idx*32 +: 32] = d;
      ew[idx*4 +: 4] = w;
      ea[idx*IMEM_AW +: IMEM_AW] = a;
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (cl_imem_dina !== ed || cl_imem_wea !== ew || cl_imem_addra !== ea) begin
        fails++;
        $display("[TB] FAIL imem%0d_c%0d: got wea=%h dina_hi=%h, expected wea=%h dina_hi=%h",
                 n, idx, cl_imem_wea, cl_imem_dina[255:224], ew, ed[255:224]);
      end
    end
    imem_dina = '0;
    imem_wea = '0;
    imem_addra = '0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (cl_imem_dina !== '0 || cl_imem_wea !== '0 || cl_imem_addra !== '0) begin
      fails++;
      $display("[TB] FAIL imem_idle: got wea=%h, expected 0", cl_imem_wea);
    end
  endtask

  task automatic test_finish;
    int            p[CL];
    int            last, vbad, fbad;
    logic [CL-1:0] ev;
    last = 0;
    for (int i = 0; i < CL; i++) begin
      p[i] = $urandom_range(0, 10);
      if (p[i] > last) last = p[i];
    end
    vbad = 0;
    fbad = 0;
    @(negedge clk);
    for (int c = 0; c <= last + 4; c++) begin
      for (int i = 0; i < CL; i++) cl_finish[i] = (p[i] == c);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < CL; i++) ev[i] = (p[i] <= c);
      if (finish_vec !== ev) vbad++;
      if (finish !== (last <= c - 1)) fbad++;
    end
    cl_finish = '0;
    tests++;
    if (vbad != 0) begin
      fails++;
      $display("[TB] FAIL finish_vec_track: got %0d bad cycles, expected 0", vbad);
    end
    tests++;
    if (fbad != 0) begin
      fails++;
      $display("[TB] FAIL finish_rise: got %0d bad cycles, expected 0", fbad);
    end

    finish_clr = 1'b1;
    cl_finish = 8'h04;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (finish_vec !== 8'h04 || finish !== 1'b1) begin
      fails++;
      $display("[TB] FAIL finish_set_wins: got vec=%h fin=%b, expected vec=04 fin=1", finish_vec, finish);
    end
    cl_finish = '0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (finish_vec !== 8'h00 || finish !== 1'b0) begin
      fails++;
      $display("[TB] FAIL finish_clear: got vec=%h fin=%b, expected vec=00 fin=0", finish_vec, finish);
    end
    finish_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (finish_vec !== 8'h00 || finish !== 1'b0) begin
      fails++;
      $display("[TB] FAIL finish_stays_clear: got vec=%h fin=%b, expected vec=00 fin=0", finish_vec, finish);
    end
  endtask

  initial begin
    for (int i = 0; i < CL; i++) begin
      gnt_dly[i] = 1;
      rd_data[i] = '0;
    end
    rv_dly = 1;
    stall = 0;
    test_reset();
    test_single_write();
    test_broadcast();
    test_read();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_imem();
    test_finish();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
